// File: rtl/field_capture_fsm_pkg.sv
// field_capture_pkg
//   Shared types and helpers for the field_capture_fsm slice: the capture
//   state enum and the counter-width helper used to size word_cnt.
//   Optional feature macro used elsewhere in this slice: FIELD_CAPTURE_MATCH_EN.
package field_capture_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    CAPTURE
  } field_cap_state_t;

  // Width of a counter indexing n items, never narrower than one bit.
  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/field_capture_fsm_if.sv
// field_capture_fsm_if
//   Groups the byte-stream inputs and the captured-field outputs of one
//   field_capture_fsm instance.
//   Stream side : start_i, abort_i, offset_i, data_i, valid_i
//   Field side  : field_o, field_valid_o, busy_o, truncated_o
//   FIELD_CAPTURE_MATCH_EN adds match_value_i (in) and match_o (out).
//   Modports: master = stream source / field consumer, slave = the extractor.
interface field_capture_fsm_if #(
  parameter int DATA_IN_W = 8,
  parameter int NUM_WORDS = 6,
  parameter int OFFSET_W  = 11
);

  logic                           start_i;
  logic                           abort_i;
  logic [OFFSET_W-1:0]            offset_i;
  logic [DATA_IN_W-1:0]           data_i;
  logic                           valid_i;
  logic [DATA_IN_W*NUM_WORDS-1:0] field_o;
  logic                           field_valid_o;
  logic                           busy_o;
  logic                           truncated_o;

`ifdef FIELD_CAPTURE_MATCH_EN
  logic [DATA_IN_W*NUM_WORDS-1:0] match_value_i;
  logic                           match_o;

  modport master (
    output start_i, abort_i, offset_i, data_i, valid_i, match_value_i,
    input  field_o, field_valid_o, busy_o, truncated_o, match_o
  );

  modport slave (
    input  start_i, abort_i, offset_i, data_i, valid_i, match_value_i,
    output field_o, field_valid_o, busy_o, truncated_o, match_o
  );
`else
  modport master (
    output start_i, abort_i, offset_i, data_i, valid_i,
    input  field_o, field_valid_o, busy_o, truncated_o
  );

  modport slave (
    input  start_i, abort_i, offset_i, data_i, valid_i,
    output field_o, field_valid_o, busy_o, truncated_o
  );
`endif

endinterface

// File: rtl/field_capture_fsm_slot_writer.sv
// field_slot_writer
//   Staging register for one field: writes wr_data into word slot wr_idx
//   when wr_en is high. MSB_FIRST=1 puts slot 0 in the top slice, 0 puts
//   it in the bottom slice.
//   Ports: clk, rst (async, active-low), wr_en, wr_idx, wr_data,
//          staged_next (staging contents including this cycle's write).
module field_slot_writer
  import field_capture_pkg::*;
#(
  parameter int DATA_IN_W = 8,
  parameter int NUM_WORDS = 6,
  parameter int MSB_FIRST = 1,
  parameter int IDX_W     = cnt_w(NUM_WORDS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [IDX_W-1:0]               wr_idx,
  input  logic [DATA_IN_W-1:0]           wr_data,
  output logic [DATA_IN_W*NUM_WORDS-1:0] staged_next
);

  localparam int FW = DATA_IN_W * NUM_WORDS;

  logic [FW-1:0] staged_q;

  function automatic int slot_lsb(input int k);
    return (MSB_FIRST != 0) ? (NUM_WORDS - 1 - k) * DATA_IN_W : k * DATA_IN_W;
  endfunction

  // staged_next is exported so the completing word can be folded into the
  // field in the same cycle it arrives.
  always_comb begin
    staged_next = staged_q;
    if (wr_en) begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        if (wr_idx == IDX_W'(k)) begin
          staged_next[slot_lsb(k) +: DATA_IN_W] = wr_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      staged_q <= '0;
    end else begin
      staged_q <= staged_next;
    end
  end

endmodule

// File: rtl/field_capture_fsm.sv
// field_capture_fsm
//   Offset-addressed field extractor for a byte stream. Counts valid words
//   from a start beat, skips offset_i words, then packs NUM_WORDS words into
//   field_o, announced by a one-cycle field_valid_o pulse.
//   Ports: clk, rst (async, active-low), bus (field_capture_fsm_if.slave).
//   Optional: FIELD_CAPTURE_MATCH_EN adds a registered compare of the
//   completed field against bus.match_value_i on bus.match_o.
module field_capture_fsm
  import field_capture_pkg::*;
#(
  parameter int DATA_IN_W = 8,
  parameter int NUM_WORDS = 6,
  parameter int OFFSET_W  = 11,
  parameter int MSB_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  field_capture_fsm_if.slave   bus
);

  localparam int                CW        = cnt_w(NUM_WORDS);
  localparam int                FW        = DATA_IN_W * NUM_WORDS;
  localparam logic [CW-1:0]     LAST_SLOT = CW'(NUM_WORDS - 1);
  localparam logic [OFFSET_W-1:0] SKIP_MAX = '1;
  localparam bit                SINGLE    = (NUM_WORDS == 1);

  field_cap_state_t     state_q, state_d;
  logic [OFFSET_W-1:0]  skip_cnt_q;
  logic [OFFSET_W-1:0]  offset_q;
  logic [CW-1:0]        word_cnt_q;
  logic [FW-1:0]        field_q;
  logic                 field_valid_q;
  logic                 truncated_q;

  logic                 start_beat;
  logic                 skip_hit;
  logic                 cap_first;
  logic                 wr_en;
  logic [CW-1:0]        wr_idx;
  logic                 complete;
  logic                 truncate;
  logic                 skip_load;
  logic                 skip_inc;
  logic [FW-1:0]        staged_next;

  // Abort beats any start on the same cycle.
  assign start_beat = bus.start_i && bus.valid_i && !bus.abort_i;
  assign skip_hit   = (state_q == SKIP) && (skip_cnt_q == offset_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A single-word field completes on its first capture beat, so the
  // capture-start paths go straight back to IDLE in that configuration.
  always_comb begin
    state_d = state_q;
    if (bus.abort_i) begin
      state_d = IDLE;
    end else if (start_beat) begin
      if (bus.offset_i == '0) begin
        state_d = SINGLE ? IDLE : CAPTURE;
      end else begin
        state_d = SKIP;
      end
    end else if (bus.valid_i) begin
      case (state_q)
        SKIP: begin
          if (skip_hit) begin
            state_d = SINGLE ? IDLE : CAPTURE;
          end
        end
        CAPTURE: begin
          if (word_cnt_q == LAST_SLOT) begin
            state_d = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // Start is tested before the CAPTURE completion path so a restart on the
  // last word drops the capture instead of publishing it.
  always_comb begin
    cap_first = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = word_cnt_q;
    complete  = 1'b0;
    truncate  = 1'b0;
    skip_load = 1'b0;
    skip_inc  = 1'b0;
    if (bus.abort_i) begin
      truncate = (state_q == CAPTURE);
    end else if (start_beat) begin
      truncate = (state_q == CAPTURE);
      if (bus.offset_i == '0) begin
        cap_first = 1'b1;
        wr_en     = 1'b1;
        wr_idx    = '0;
        complete  = SINGLE;
      end else begin
        skip_load = 1'b1;
      end
    end else if (bus.valid_i) begin
      case (state_q)
        SKIP: begin
          if (skip_hit) begin
            cap_first = 1'b1;
            wr_en     = 1'b1;
            wr_idx    = '0;
            complete  = SINGLE;
          end else begin
            skip_inc = 1'b1;
          end
        end
        CAPTURE: begin
          wr_en    = 1'b1;
          wr_idx   = word_cnt_q;
          complete = (word_cnt_q == LAST_SLOT);
        end
        default: ;
      endcase
    end
  end

  // skip_cnt saturates rather than wrapping so a huge offset can never
  // alias onto a small one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skip_cnt_q    <= '0;
      offset_q      <= '0;
      word_cnt_q    <= '0;
      field_q       <= '0;
      field_valid_q <= 1'b0;
      truncated_q   <= 1'b0;
    end else begin
      if (skip_load) begin
        offset_q   <= bus.offset_i;
        skip_cnt_q <= OFFSET_W'(1);
      end else if (skip_inc && (skip_cnt_q != SKIP_MAX)) begin
        skip_cnt_q <= skip_cnt_q + OFFSET_W'(1);
      end
      if (wr_en) begin
        if (complete) begin
          word_cnt_q <= '0;
        end else if (cap_first) begin
          word_cnt_q <= CW'(1);
        end else begin
          word_cnt_q <= word_cnt_q + CW'(1);
        end
      end
      if (complete) begin
        field_q <= staged_next;
      end
      field_valid_q <= complete;
      truncated_q   <= truncate;
    end
  end

  field_slot_writer #(
    .DATA_IN_W (DATA_IN_W),
    .NUM_WORDS (NUM_WORDS),
    .MSB_FIRST (MSB_FIRST),
    .IDX_W     (CW)
  ) u_slot_writer (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_data     (bus.data_i),
    .staged_next (staged_next)
  );

`ifdef FIELD_CAPTURE_MATCH_EN
  logic match_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_q <= 1'b0;
    end else if (complete) begin
      match_q <= (staged_next == bus.match_value_i);
    end
  end

  assign bus.match_o = match_q;
`endif

  assign bus.field_o       = field_q;
  assign bus.field_valid_o = field_valid_q;
  assign bus.busy_o        = (state_q != IDLE);
  assign bus.truncated_o   = truncated_q;

endmodule

// File: tb/tb_field_capture_fsm.sv
// tb_field_capture_fsm
//   Directed bench for field_capture_fsm. Three instances share one stream:
//   a 6-word MAC extractor and two 2-word EtherType extractors that differ
//   only in byte order. With FIELD_CAPTURE_MATCH_EN defined the MAC
//   instance's match output is also checked.
module tb_field_capture_fsm;

  logic clk;
  logic rst;

  int vec_count;
  int miss_count;

  field_capture_fsm_if #(.DATA_IN_W(8), .NUM_WORDS(6), .OFFSET_W(11)) if6  ();
  field_capture_fsm_if #(.DATA_IN_W(8), .NUM_WORDS(2), .OFFSET_W(11)) if2m ();
  field_capture_fsm_if #(.DATA_IN_W(8), .NUM_WORDS(2), .OFFSET_W(11)) if2l ();

  field_capture_fsm #(.DATA_IN_W(8), .NUM_WORDS(6), .OFFSET_W(11), .MSB_FIRST(1)) u_mac (
    .clk (clk), .rst (rst), .bus (if6.slave)
  );

  field_capture_fsm #(.DATA_IN_W(8), .NUM_WORDS(2), .OFFSET_W(11), .MSB_FIRST(1)) u_et_msb (
    .clk (clk), .rst (rst), .bus (if2m.slave)
  );

  field_capture_fsm #(.DATA_IN_W(8), .NUM_WORDS(2), .OFFSET_W(11), .MSB_FIRST(0)) u_et_lsb (
    .clk (clk), .rst (rst), .bus (if2l.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] frame [14] = '{8'h00, 8'h1A, 8'h2B, 8'h3C, 8'h4D, 8'h5E, 8'h77,
                             8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'h08, 8'h00};
  logic [7:0] frame2 [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic [7:0] ucast [6]  = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Drives one beat on all three instances, then returns 1 time unit after
  // the clock edge that consumed it.
  task automatic applyStimulus(input logic start, input logic abort,
                               input logic [10:0] offset, input logic [7:0] data,
                               input logic valid);
    if6.start_i  = start;  if2m.start_i  = start;  if2l.start_i  = start;
    if6.abort_i  = abort;  if2m.abort_i  = abort;  if2l.abort_i  = abort;
    if6.offset_i = offset; if2m.offset_i = offset; if2l.offset_i = offset;
    if6.data_i   = data;   if2m.data_i   = data;   if2l.data_i   = data;
    if6.valid_i  = valid;  if2m.valid_i  = valid;  if2l.valid_i  = valid;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_count  = 0;
    miss_count = 0;
    rst = 1'b0;
    if6.start_i = 1'b0; if6.abort_i = 1'b0; if6.offset_i = '0; if6.data_i = '0; if6.valid_i = 1'b0;
    if2m.start_i = 1'b0; if2m.abort_i = 1'b0; if2m.offset_i = '0; if2m.data_i = '0; if2m.valid_i = 1'b0;
    if2l.start_i = 1'b0; if2l.abort_i = 1'b0; if2l.offset_i = '0; if2l.data_i = '0; if2l.valid_i = 1'b0;
`ifdef FIELD_CAPTURE_MATCH_EN
    if6.match_value_i  = 48'hFFFFFFFFFFFF;
    if2m.match_value_i = '0;
    if2l.match_value_i = '0;
`endif

    // Reset state
    #12;
    checkOutput("rst_field",     64'(if6.field_o),       64'h0);
    checkOutput("rst_valid",     64'(if6.field_valid_o), 64'h0);
    checkOutput("rst_busy",      64'(if6.busy_o),        64'h0);
    checkOutput("rst_truncated", 64'(if6.truncated_o),   64'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // MAC capture at offset 0
    $display("[TB] MAC capture, offset 0");
    applyStimulus(1'b1, 1'b0, 11'd0, frame[0], 1'b1);
    checkOutput("mac_busy_b0", 64'(if6.busy_o), 64'h1);
    applyStimulus(1'b0, 1'b0, 11'd0, frame[1], 1'b1);
    checkOutput("et2_msb_off0_valid", 64'(if2m.field_valid_o), 64'h1);
    checkOutput("et2_msb_off0_field", 64'(if2m.field_o),       64'h001A);
    checkOutput("et2_lsb_off0_field", 64'(if2l.field_o),       64'h1A00);
    for (int i = 2; i <= 4; i++) begin
      applyStimulus(1'b0, 1'b0, 11'd0, frame[i], 1'b1);
    end
    checkOutput("mac_partial_valid", 64'(if6.field_valid_o), 64'h0);
    checkOutput("mac_partial_field", 64'(if6.field_o),       64'h0);
    applyStimulus(1'b0, 1'b0, 11'd0, frame[5], 1'b1);
    checkOutput("mac_done_valid", 64'(if6.field_valid_o), 64'h1);
    checkOutput("mac_done_field", 64'(if6.field_o),       64'h001A2B3C4D5E);
    applyStimulus(1'b0, 1'b0, 11'd0, frame[6], 1'b1);
    checkOutput("mac_pulse_end", 64'(if6.field_valid_o), 64'h0);
    checkOutput("mac_idle_busy", 64'(if6.busy_o),        64'h0);
    checkOutput("mac_held",      64'(if6.field_o),       64'h001A2B3C4D5E);

    // EtherType at offset 12 with a 3-cycle gap after byte 5
    $display("[TB] EtherType capture, offset 12, valid gap");
    applyStimulus(1'b1, 1'b0, 11'd12, frame[0], 1'b1);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b0, 1'b0, 11'd0, frame[i], 1'b1);
    end
    for (int g = 0; g < 3; g++) begin
      applyStimulus(1'b0, 1'b0, 11'd0, 8'hEE, 1'b0);
    end
    checkOutput("et_gap_busy", 64'(if2m.busy_o), 64'h1);
    for (int i = 6; i <= 12; i++) begin
      applyStimulus(1'b0, 1'b0, 11'd0, frame[i], 1'b1);
    end
    checkOutput("et_b12_valid", 64'(if2m.field_valid_o), 64'h0);
    checkOutput("et_b12_field", 64'(if2m.field_o),       64'h001A);
    applyStimulus(1'b0, 1'b0, 11'd0, frame[13], 1'b1);
    checkOutput("et_msb_valid", 64'(if2m.field_valid_o), 64'h1);
    checkOutput("et_msb_field", 64'(if2m.field_o),       64'h0800);
    checkOutput("et_lsb_field", 64'(if2l.field_o),       64'h0008);

    // The MAC instance is mid-capture at bytes 12..13; abort it there.
    $display("[TB] Abort during CAPTURE and SKIP");
    applyStimulus(1'b0, 1'b1, 11'd0, 8'h00, 1'b0);
    checkOutput("abort_cap_trunc", 64'(if6.truncated_o),   64'h1);
    checkOutput("abort_cap_busy",  64'(if6.busy_o),        64'h0);
    checkOutput("abort_cap_field", 64'(if6.field_o),       64'h001A2B3C4D5E);
    checkOutput("abort_cap_valid", 64'(if6.field_valid_o), 64'h0);
    checkOutput("abort_idle_trunc", 64'(if2m.truncated_o), 64'h0);
    applyStimulus(1'b0, 1'b0, 11'd0, 8'h00, 1'b0);
    checkOutput("abort_trunc_end", 64'(if6.truncated_o), 64'h0);

    applyStimulus(1'b1, 1'b0, 11'd5, 8'h01, 1'b1);
    applyStimulus(1'b0, 1'b0, 11'd0, 8'h02, 1'b1);
    checkOutput("skip_busy", 64'(if6.busy_o), 64'h1);
    applyStimulus(1'b0, 1'b1, 11'd0, 8'h00, 1'b0);
    checkOutput("abort_skip_trunc", 64'(if6.truncated_o), 64'h0);
    checkOutput("abort_skip_busy",  64'(if6.busy_o),      64'h0);
    applyStimulus(1'b1, 1'b1, 11'd0, 8'h55, 1'b1);
    checkOutput("abort_start_busy", 64'(if6.busy_o), 64'h0);
    applyStimulus(1'b0, 1'b0, 11'd0, 8'h66, 1'b1);
    checkOutput("abort_start_idle", 64'(if6.busy_o), 64'h0);

    // Restart mid-capture
    $display("[TB] Restart mid-capture");
    applyStimulus(1'b1, 1'b0, 11'd2, 8'hA0, 1'b1);
    applyStimulus(1'b0, 1'b0, 11'd0, 8'hA1, 1'b1);
    applyStimulus(1'b0, 1'b0, 11'd0, 8'hA2, 1'b1);
    applyStimulus(1'b1, 1'b0, 11'd0, frame2[0], 1'b1);
    checkOutput("restart_trunc", 64'(if6.truncated_o), 64'h1);
    checkOutput("restart_busy",  64'(if6.busy_o),      64'h1);
    checkOutput("restart_field", 64'(if6.field_o),     64'h001A2B3C4D5E);
    applyStimulus(1'b0, 1'b0, 11'd0, frame2[1], 1'b1);
    checkOutput("restart_trunc_once", 64'(if6.truncated_o), 64'h0);
    for (int i = 2; i <= 4; i++) begin
      applyStimulus(1'b0, 1'b0, 11'd0, frame2[i], 1'b1);
    end
    checkOutput("restart_partial", 64'(if6.field_o), 64'h001A2B3C4D5E);
    applyStimulus(1'b0, 1'b0, 11'd0, frame2[5], 1'b1);
    checkOutput("restart_valid", 64'(if6.field_valid_o), 64'h1);
    checkOutput("restart_field_new", 64'(if6.field_o),   64'h112233445566);

    // Start on the last word wins over completion (2-word instances)
    $display("[TB] Start beats completion");
    applyStimulus(1'b1, 1'b0, 11'd0, 8'hAA, 1'b1);
    applyStimulus(1'b1, 1'b0, 11'd0, 8'hBB, 1'b1);
    checkOutput("prio_valid", 64'(if2m.field_valid_o), 64'h0);
    checkOutput("prio_trunc", 64'(if2m.truncated_o),   64'h1);
    checkOutput("prio_held",  64'(if2m.field_o),       64'h1122);
    applyStimulus(1'b0, 1'b0, 11'd0, 8'hCC, 1'b1);
    checkOutput("prio_msb_field", 64'(if2m.field_o), 64'hBBCC);
    checkOutput("prio_lsb_field", 64'(if2l.field_o), 64'hCCBB);
    applyStimulus(1'b0, 1'b1, 11'd0, 8'h00, 1'b0);

    // Async reset mid-CAPTURE, between clock edges
    $display("[TB] Async reset mid-capture");
    applyStimulus(1'b1, 1'b0, 11'd0, 8'h12, 1'b1);
    applyStimulus(1'b0, 1'b0, 11'd0, 8'h34, 1'b1);
    rst = 1'b0;
    #2;
    checkOutput("areset_busy",  64'(if6.busy_o),         64'h0);
    checkOutput("areset_field", 64'(if6.field_o),        64'h0);
    checkOutput("areset_pulse", 64'(if2m.field_valid_o), 64'h0);
    checkOutput("areset_f2",    64'(if2m.field_o),       64'h0);
    #3;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 11'd0, 8'h00, 1'b0);

    // Broadcast then unicast capture after reset
    $display("[TB] Post-reset broadcast and unicast");
    applyStimulus(1'b1, 1'b0, 11'd0, 8'hFF, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b0, 1'b0, 11'd0, 8'hFF, 1'b1);
    end
    checkOutput("bcast_valid", 64'(if6.field_valid_o), 64'h1);
    checkOutput("bcast_field", 64'(if6.field_o),       64'hFFFFFFFFFFFF);
`ifdef FIELD_CAPTURE_MATCH_EN
    checkOutput("bcast_match", 64'(if6.match_o), 64'h1);
`endif
    applyStimulus(1'b0, 1'b0, 11'd0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 11'd0, ucast[0], 1'b1);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b0, 1'b0, 11'd0, ucast[i], 1'b1);
    end
    checkOutput("ucast_field", 64'(if6.field_o), 64'h020000000001);
`ifdef FIELD_CAPTURE_MATCH_EN
    checkOutput("ucast_match", 64'(if6.match_o), 64'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/field_capture_fsm.md
Name: field_capture_fsm

Overview:
- Offset-addressed field extractor for the 1G Ethernet byte stream.
- Counts valid words from a frame-start marker, skips a runtime-programmable number of words, then packs NUM_WORDS consecutive words into one wide field.
- Presents the field with a one-cycle valid pulse and holds it until the next capture completes.
- Sits beside the parser datapath: one instance per header field (dst MAC, src MAC, EtherType, ...). Supports valid gaps, restart, abort and configurable byte order.

Parameters:
- DATA_IN_W, 8: width of one input word.
- NUM_WORDS, 6: words per captured field; must be >= 1.
- OFFSET_W, 11: width of the offset_i skip count.
- MSB_FIRST, 1: 1 places the first captured word in the top slice (network order); 0 places it in the bottom slice.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low (asserted at 0)
- start_i  in  1  frame start; qualified by valid_i; marks word index 0
- abort_i  in  1  discard capture in progress
- offset_i  in  OFFSET_W  words to skip before capture; sampled on the start beat
- data_i  in  DATA_IN_W  input word
- valid_i  in  1  data_i valid
- field_o  out  DATA_IN_W*NUM_WORDS  captured field; held between captures
- field_valid_o  out  1  one-cycle pulse when field_o is updated
- busy_o  out  1  high in SKIP or CAPTURE
- truncated_o  out  1  one-cycle pulse when a capture is cut short by a restart or abort

Behaviour:
- Reset (rst=0, async): state IDLE; counters 0; field_o=0; field_valid_o=0; busy_o=0; truncated_o=0.
- States: IDLE, SKIP, CAPTURE. Counters advance only on cycles with valid_i=1; gaps freeze all state.
- IDLE, on start_i && valid_i:
  - offset_i=0: that beat is capture word 0; go to CAPTURE. With NUM_WORDS=1 the capture completes on this beat.
  - otherwise: latch offset_i; skip_cnt=1; go to SKIP.
- SKIP: each valid beat increments skip_cnt. The beat on which skip_cnt equals the latched offset is capture word 0; go to CAPTURE.
- CAPTURE:
  - Each valid beat writes data_i into word slot word_cnt of an internal staging register.
  - MSB_FIRST=1: slot k occupies bits [(NUM_WORDS-k)*DATA_IN_W-1 -: DATA_IN_W]. MSB_FIRST=0: bits [k*DATA_IN_W +: DATA_IN_W].
  - On slot NUM_WORDS-1: copy staging into field_o; pulse field_valid_o on the next cycle (latency 1 from the last word); return to IDLE.
- field_o changes only on completion. A partial capture never alters field_o.
- start_i && valid_i while busy: the current capture is dropped and restarts with the new offset_i. truncated_o pulses if the state was CAPTURE. start takes priority over completion on the same beat.
- abort_i (any state): return to IDLE next cycle; pulse truncated_o if the state was CAPTURE.
- abort_i together with start_i: abort wins; the start is ignored.
- Arithmetic:
  - skip_cnt is OFFSET_W bits and saturates; it never wraps.
  - word_cnt is $clog2(NUM_WORDS) bits, minimum 1.
- A frame shorter than offset+NUM_WORDS words: the block stays busy until the next start or abort. The parser must issue abort_i at end of frame.

Optional Feature:
- Macro: FIELD_CAPTURE_MATCH_EN.
- Defined: adds input match_value_i (DATA_IN_W*NUM_WORDS) and output match_o (1).
  - match_o is registered and updates in the same cycle as field_valid_o: 1 if the completed field equals match_value_i, else 0.
  - match_o holds its value until the next completion. Reset value 0.
- Undefined: neither port exists and there is no comparator logic.

Decomposition:
- field_capture_pkg holds:
  - state enum typedef field_cap_state_t {IDLE, SKIP, CAPTURE};
  - function cnt_w(n) = max(1, $clog2(n)).
- One sub-module, field_slot_writer: a staging register with an indexed slot write and MSB_FIRST slice mapping, driven by word_cnt and a write enable.

Test Plan:
- MAC capture: DATA_IN_W=8, NUM_WORDS=6, offset 0, frame bytes 00 1A 2B 3C 4D 5E 77 ... -> field_valid_o pulses the cycle after byte 5; field_o=48'h001A2B3C4D5E; busy_o low afterwards.
- EtherType: NUM_WORDS=2, offset 12, bytes 12=08 and 13=00, with valid_i low for 3 cycles between bytes 5 and 6 -> field_o=16'h0800, pulse one cycle after byte 13; with MSB_FIRST=0 -> 16'h0008.
- Restart mid-capture: offset 2, new start_i at the 4th byte with offset 0 -> truncated_o pulses once; field_o keeps its old value until the new frame's 6th byte completes.
- Abort: abort_i during SKIP -> no truncated_o; abort_i during CAPTURE -> truncated_o pulse, field_o unchanged, busy_o=0 next cycle. abort_i together with start_i -> stays IDLE.
- Async reset mid-CAPTURE: rst low between clock edges -> all outputs 0 immediately; after release, a new start captures correctly.
- FIELD_CAPTURE_MATCH_EN: match_value_i=48'hFFFFFFFFFFFF, broadcast frame -> match_o=1 with field_valid_o; next unicast frame -> match_o=0.
